// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter sharing one bit-serial adder among four requesters.
// The winner's operands are shifted LSB-first through a full adder; the result is staged and published on DONE.
module serial_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             req,
    input  logic [4*WIDTH-1:0]     a_in,
    input  logic [4*WIDTH-1:0]     b_in,
    output logic [3:0]             gnt,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             done_id,
    output logic [WIDTH-1:0]       sum,
    output logic                   cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gid_q, gid_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             win_found_s;
    logic [1:0]       win_id_s;
    logic [WIDTH-1:0] a_sel_s, b_sel_s;
    logic             fa_s_s, fa_c_s;

    // Round-robin search starting at ptr: first requester found wins.
    always_comb begin : arb_search
        logic [1:0] cand;
        cand        = 2'd0;
        win_found_s = 1'b0;
        win_id_s    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found_s && req[cand]) begin
                win_found_s = 1'b1;
                win_id_s    = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Operand slice of the granted requester.
    always_comb begin
        a_sel_s = a_in[0 +: WIDTH];
        b_sel_s = b_in[0 +: WIDTH];
        case (gid_q)
            2'd0: begin a_sel_s = a_in[0*WIDTH +: WIDTH]; b_sel_s = b_in[0*WIDTH +: WIDTH]; end
            2'd1: begin a_sel_s = a_in[1*WIDTH +: WIDTH]; b_sel_s = b_in[1*WIDTH +: WIDTH]; end
            2'd2: begin a_sel_s = a_in[2*WIDTH +: WIDTH]; b_sel_s = b_in[2*WIDTH +: WIDTH]; end
            2'd3: begin a_sel_s = a_in[3*WIDTH +: WIDTH]; b_sel_s = b_in[3*WIDTH +: WIDTH]; end
            default: begin a_sel_s = '0; b_sel_s = '0; end
        endcase
    end

    // Single full adder fed by the shift-register LSBs and the carry flop.
    always_comb begin
        fa_s_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_c_s = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    // Next-state logic for the FSM, datapath and registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    gid_d   = win_id_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                a_sr_d   = a_sel_s;
                b_sr_d   = b_sel_s;
                sum_sr_d = '0;
                carry_d  = 1'b0;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = {fa_s_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_c_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                ptr_d   = gid_q + 2'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid in that cycle.
        gnt_d  = (state_d == ST_IDLE) ? 4'b0000 : onehot4(gid_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            sum_d     = sum_sr_d;
            cout_d    = carry_d;
            done_id_d = gid_q;
        end else begin
            sum_d     = sum_q;
            cout_d    = cout_q;
            done_id_d = done_id_q;
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            gid_q     <= 2'd0;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 2'd0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule
